pcie_tx_arbiter: RTL
====================

Name: pcie_tx_arbiter

Overview:
Shares the single PCIe core AXI4-Stream TX port (s_axis_tx_*) among NUM_REQ internal TLP sources, for example a completion generator and a DMA read-request engine. Each source uses a req/ack handshake: it raises req, waits for ack, streams exactly one TLP, then releases. The arbiter is round-robin and packet-atomic: a grant is never revoked mid-TLP. It sits between the app-level TLP sources and the 7-series PCIe core TX interface, inside the pcie_app_7x hierarchy.

Parameters:
C_DATA_WIDTH, 64, TX datapath width in bits (64 only for this board)
KEEP_WIDTH, C_DATA_WIDTH/8, byte-enable width
NUM_REQ, 2, number of requesters, legal range 2..4

Ports:
user_clk  in  1  core user clock; all logic is on this edge
user_reset  in  1  synchronous, active-high reset
user_lnk_up  in  1  link up; when low, no new grants are issued
src_req  in  NUM_REQ  per-source request, level
src_ack  out  NUM_REQ  per-source grant, registered, one-hot or zero
src_tdata  in  NUM_REQ*C_DATA_WIDTH  packed per-source data, source i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
src_tkeep  in  NUM_REQ*KEEP_WIDTH  packed per-source keep
src_tuser  in  NUM_REQ*4  packed per-source tuser
src_tlast  in  NUM_REQ  per-source tlast
src_tvalid  in  NUM_REQ  per-source tvalid
src_tready  out  NUM_REQ  per-source tready
s_axis_tx_tready  in  1  core ready
s_axis_tx_tdata  out  C_DATA_WIDTH  to core
s_axis_tx_tkeep  out  KEEP_WIDTH  to core
s_axis_tx_tuser  out  4  to core
s_axis_tx_tlast  out  1  to core
s_axis_tx_tvalid  out  1  to core
pkt_cnt  out  NUM_REQ*32  per-source completed-TLP counters (see Optional Feature)

Behaviour:
- Reset (user_reset=1 at the clock edge): state=IDLE, src_ack=0, rr_ptr=0, pkt_cnt=0. All s_axis_tx_* outputs are 0 and all src_tready are 0 from the same cycle, because they are gated by state.
- States:
  - IDLE: each cycle, if user_lnk_up=1 and src_req!=0, pick the first set req scanning from rr_ptr upward with wrap mod NUM_REQ. Register grant=winner, set src_ack[winner]=1, go to XFER. Latency from req sample to ack is 1 cycle.
  - XFER: datapath mux is driven from the registered grant index g.
    - s_axis_tx_tvalid = src_tvalid[g]
    - s_axis_tx_tdata/tkeep/tuser/tlast = source g fields
    - src_tready[g] = s_axis_tx_tready; all other src_tready = 0
  - Last beat: the beat with s_axis_tx_tvalid & s_axis_tx_tready & s_axis_tx_tlast. On that beat, next state is IDLE, src_ack is cleared on the next edge, and rr_ptr = (g+1) mod NUM_REQ.
- Idle gating: outside XFER, s_axis_tx_tvalid=0 and s_axis_tx_tdata/tkeep/tuser/tlast=0.
- Inter-packet gap: there is a mandatory 1-cycle IDLE bubble between TLPs, so back-to-back throughput is at most 1 TLP per (beats+1) cycles.
- Fairness: with all sources continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0...
- Source drops req during XFER: the grant is held until that source's last beat. Packet integrity takes priority.
- Source drops req before it is sampled in IDLE: the source is not considered.
- user_lnk_up falls during XFER: the current TLP completes, then no new grant is issued until the link returns.
- Reset mid-packet: immediate return to IDLE, the partial TLP is abandoned, and no state is retained. The core is in reset at the same time.
- tvalid low mid-packet: legal. The arbiter waits with no timeout.
- Backpressure: data passes straight through with no buffering and zero added latency on the data path.

Optional Feature:
PCIE_TX_ARB_STATS_EN
- Defined: pkt_cnt[i*32 +: 32] increments by 1 on each last beat of source i. It is 32-bit, wraps 0xFFFFFFFF -> 0, and is cleared by reset.
- Undefined: the counter logic is not built and pkt_cnt is tied to 0. The port list is unchanged.

Test Plan:
- Single source: src_req=01, a 3-beat TLP, tready=1 -> src_ack[0]=1 one cycle after req, exactly 3 beats seen on s_axis_tx with tlast on beat 3, ack=0 the cycle after the last beat, rr_ptr=1.
- Contention: src_req=11 simultaneously from reset, 2-beat TLPs, both re-request continuously for 6 packets -> grant order 0,1,0,1,0,1 with a 1-cycle bubble between packets.
- Backpressure: s_axis_tx_tready toggles 1,0,1,0 during a 4-beat TLP from source 1 -> src_tready[1] mirrors tready, src_tready[0]=0 throughout, data order intact, 4 accepted beats.
- Link down: drop user_lnk_up on beat 2 of a 4-beat TLP with src_req=11 -> TLP completes, no ack while the link is low, and source 1 is granted 1 cycle after the link returns.
- Reset mid-packet: user_reset on beat 2 -> next cycle src_ack=0, s_axis_tx_tvalid=0, state IDLE; a subsequent request from source 1 is granted first (rr_ptr=0 scan, source 0 idle).
- Stats (macro defined): preload counter 0 to 0xFFFFFFFE via force, send 2 TLPs from source 0 -> counter reads 0xFFFFFFFF then 0x00000000; with the macro undefined pkt_cnt stays 0.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Round-robin, packet-atomic arbiter that shares the PCIe core AXI4-Stream TX port among NUM_REQ TLP sources.
// Optional build macro PCIE_TX_ARB_STATS_EN adds per-source completed-TLP counters on pkt_cnt.
module pcie_tx_arbiter #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int NUM_REQ      = 2
) (
    input  logic                            user_clk,
    input  logic                            user_reset,
    input  logic                            user_lnk_up,
    input  logic [NUM_REQ-1:0]              src_req,
    output logic [NUM_REQ-1:0]              src_ack,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]   src_tkeep,
    input  logic [NUM_REQ*4-1:0]            src_tuser,
    input  logic [NUM_REQ-1:0]              src_tlast,
    input  logic [NUM_REQ-1:0]              src_tvalid,
    output logic [NUM_REQ-1:0]              src_tready,
    input  logic                            s_axis_tx_tready,
    output logic [C_DATA_WIDTH-1:0]         s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]           s_axis_tx_tkeep,
    output logic [3:0]                      s_axis_tx_tuser,
    output logic                            s_axis_tx_tlast,
    output logic                            s_axis_tx_tvalid,
    output logic [NUM_REQ*32-1:0]           pkt_cnt
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [IDX_W-1:0]   winner, cand;
    logic               found;
    logic               last_beat;

    // Round-robin scan: first requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && src_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign last_beat = (state_q == XFER) && s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast;

    always_ff @(posedge user_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (user_reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        ack_d    = ack_q;
        unique case (state_q)
            IDLE: begin
                if (user_lnk_up && found) begin
                    state_d        = XFER;
                    grant_d        = winner;
                    ack_d          = '0;
                    ack_d[winner]  = 1'b1;
                end
            end
            XFER: begin
                // Grant is held until the granted source's last beat, regardless of req or link.
                if (last_beat) begin
                    state_d  = IDLE;
                    ack_d    = '0;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tx_tvalid = 1'b0;
        s_axis_tx_tdata  = '0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tuser  = '0;
        s_axis_tx_tlast  = 1'b0;
        src_tready       = '0;
        if (state_q == XFER) begin
            s_axis_tx_tvalid    = src_tvalid[grant_q];
            s_axis_tx_tdata     = src_tdata[int'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
            s_axis_tx_tkeep     = src_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
            s_axis_tx_tuser     = src_tuser[int'(grant_q)*4 +: 4];
            s_axis_tx_tlast     = src_tlast[grant_q];
            src_tready[grant_q] = s_axis_tx_tready;
        end
    end

    assign src_ack = ack_q;

`ifdef PCIE_TX_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (last_beat) begin
            pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule
